pes_clk_monitor: RTL and testbench
==================================

# pes_clk_monitor

Frequency/duty monitor that sits directly downstream of the clock divider: it samples the divided clock as data in the fast source-clock domain and measures its period and high time in source-clock cycles. Each completed period produces a one-cycle `meas_valid` strobe with the results. A watchdog flags a stalled divider output. Used for bring-up checks and as a self-test consumer of the divider.

## Interface
- `CNT_W`, 28: width of the period/high-time counters and outputs.
- `TIMEOUT`, 28'd1000: cycles without a rising edge before `stalled` is raised; legal range 2 .. 2^CNT_W-2.
- `clock_in` input 1: source clock, the same clock that drives the divider; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clock_div` input 1: divided clock under test; treated as asynchronous data.
- `period` output CNT_W: last measured period in `clock_in` cycles.
- `high_time` output CNT_W: last measured high time in `clock_in` cycles.
- `meas_valid` output 1: one-cycle strobe; `period`/`high_time` updated this cycle.
- `stalled` output 1: level; no rising edge for `TIMEOUT` cycles.
- `meas_count` output 16: number of measurements since reset, wraps 0xFFFF→0.

## Operation
- Synchronizer: `s1 <= clock_div`, `s2 <= s1`, `s3 <= s2`. `rise = s2 & ~s3`. Only `s2` is used as the sampled level.
- State machine, reset state ARM:
  - ARM: counters held at 0. On `rise`: go to RUN, `pcnt <= 1`, `hcnt <= 1`, no strobe. The first edge never produces a measurement.
  - RUN, with priority rise > timeout:
    - On `rise`: `period <= pcnt`, `high_time <= hcnt`, `meas_valid <= 1`, `meas_count++`, `pcnt <= 1`, `hcnt <= 1`.
    - Otherwise, if `pcnt >= TIMEOUT`: go to STALL, set `stalled <= 1`. Counters freeze.
    - Otherwise: `pcnt <= pcnt + 1`, and `hcnt <= hcnt + 1` when `s2 == 1`.
  - STALL: `stalled` stays 1. On `rise`: go to RUN, clear `stalled`, `pcnt <= 1`, `hcnt <= 1`, no strobe. The period spanning the stall is discarded.
- A `rise` in the same cycle that `pcnt == TIMEOUT` is a valid measurement with `period = TIMEOUT`; `stalled` is not set.
- `pcnt` never exceeds `TIMEOUT`, so it cannot overflow. `hcnt <= pcnt` always holds.
- `period` and `high_time` hold their last values between strobes and through STALL.
- Reset asserted at any time returns to ARM immediately. All outputs and sync flops clear, and any partial measurement is discarded.

## Timing
- Reset values: `period=0`, `high_time=0`, `meas_valid=0`, `stalled=0`, `meas_count=0`, `s1`–`s3` = 0, state ARM.
- Latency: `clock_div` first sampled high at `clock_in` edge N gives `rise` during the cycle after edge N+1. `meas_valid` and the outputs are registered high after edge N+2.
- `meas_valid` is high for exactly one cycle per measured period. Back-to-back strobes are only possible for a period of 1, which is illegal input.
- `stalled` rises on the edge after the cycle where `pcnt == TIMEOUT` without a `rise`. It falls on the edge after the recovering `rise`.
- Minimum measurable period is 2 cycles; no back-pressure.

## Configuration
- `PES_CLK_MON_DUTY_EN` defined: `hcnt` is implemented and `high_time` reports the measured high time.
- `PES_CLK_MON_DUTY_EN` not defined: `hcnt` is removed and `high_time` is tied to 0. The period, stall and count behaviour is unchanged.

## Test plan
- Divider output with DIVISOR=2 (pattern 1,0,…) → first strobe after the second rise, then every 2 cycles with `period=2`, `high_time=1`; `meas_count` increments by 1 per strobe.
- Divider output with DIVISOR=10 (5 high, 5 low) → `period=10`, `high_time=5`. With the macro undefined, `high_time=0` and `period=10`.
- `clock_div` stuck at 0 after 3 periods, `TIMEOUT=20` → `stalled=1` exactly 20 cycles after the last `pcnt=1` load; `period` holds 10. On restart, the first rise sends no strobe and clears `stalled`; the next rise strobes `period=10`.
- Rise arriving exactly when `pcnt == TIMEOUT` (period 20, `TIMEOUT=20`) → strobe with `period=20`, `stalled` stays 0.
- `reset_n` pulsed low mid-period while in RUN → all outputs go to 0 asynchronously, state ARM. After release, the first rise gives no strobe and the second gives the correct period.
- 65537 measurements → `meas_count` wraps to 1.

Source files
------------

// File: rtl/pes_clk_monitor.sv
// pes_clk_monitor: measures period and high time of a divided clock
// sampled as data in the source clock domain, with a stall watchdog.
//
// Ports:
//   clock_in   - source clock, all logic on its rising edge
//   reset_n    - asynchronous active-low reset
//   clock_div  - divided clock under test (asynchronous data)
//   period     - last measured period in clock_in cycles
//   high_time  - last measured high time (0 when duty measurement is off)
//   meas_valid - one-cycle strobe when period/high_time update
//   stalled    - no rising edge seen for TIMEOUT cycles
//   meas_count - measurements since reset, wraps at 16 bits
//
// Build option: define PES_CLK_MON_DUTY_EN to implement the high-time
// counter; otherwise high_time is tied to 0.

module pes_clk_monitor #(
    parameter int               CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1000)
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             clock_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stalled,
    output logic [15:0]      meas_count
);

    localparam logic [1:0] ST_ARM   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stalled_q, stalled_d;
    logic [15:0]      count_q, count_d;
    logic             cnt_load, cnt_clr, cnt_inc;

    // s2 is the sampled level; s3 only serves edge detection.
    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        count_d   = count_q;
        cnt_load  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (rise) begin
                    state_d  = ST_RUN;
                    cnt_load = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // A rise wins over the timeout, so period == TIMEOUT
                // is still a valid measurement.
                if (rise) begin
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    count_d  = count_q + 16'd1;
                    cnt_load = 1'b1;
                end else if (pcnt_q >= TIMEOUT) begin
                    state_d   = ST_STALL;
                    stalled_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STALL: begin
                // The period spanning the stall is discarded.
                if (rise) begin
                    state_d   = ST_RUN;
                    stalled_d = 1'b0;
                    cnt_load  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARM;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (cnt_load)
            pcnt_d = CNT_W'(1);
        else if (cnt_clr)
            pcnt_d = '0;
        else if (cnt_inc)
            pcnt_d = pcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= ST_ARM;
            pcnt_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            count_q   <= '0;
        end else begin
            s1_q      <= clock_div;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            count_q   <= count_d;
        end
    end

`ifdef PES_CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    // hcnt follows pcnt but only advances while the sampled level is
    // high, so hcnt <= pcnt always holds.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (valid_d)
            high_d = hcnt_q;
        if (cnt_load)
            hcnt_d = CNT_W'(1);
        else if (cnt_clr)
            hcnt_d = '0;
        else if (cnt_inc && s2_q)
            hcnt_d = hcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period     = period_q;
    assign meas_valid = valid_q;
    assign stalled    = stalled_q;
    assign meas_count = count_q;

endmodule

// File: tb/tb_pes_clk_monitor.sv
// tb_pes_clk_monitor: directed tests for pes_clk_monitor with TIMEOUT=20.
// Covers reset, DIVISOR 2/10, stall/recovery, timeout boundary, mid reset.

module tb_pes_clk_monitor;

    localparam int CNT_W = 28;
`ifdef PES_CLK_MON_DUTY_EN
    localparam int DUTY = 1;
`else
    localparam int DUTY = 0;
`endif

    logic             clock_in;
    logic             reset_n;
    logic             clock_div;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stalled;
    logic [15:0]      meas_count;

    int checks;
    int errors;

    pes_clk_monitor #(
        .CNT_W  (CNT_W),
        .TIMEOUT(CNT_W'(20))
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .clock_div (clock_div),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stalled   (stalled),
        .meas_count(meas_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Drive one clock_div sample, then step just past the next edge.
    task automatic cyc(input logic v);
        clock_div = v;
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        clock_div = 1'b0;
        reset_n   = 1'b0;
        @(posedge clock_in);
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({period, high_time, meas_valid, stalled, meas_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%b s=%b c=%0d, want all 0",
                     period, high_time, meas_valid, stalled, meas_count);
        end
    endtask

    // Pattern 1,0,...: first high sampled at i=0, strobes at i=4,6,...
    task automatic test_div2();
        int cnt;
        logic ev;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2) == 0);
            ev = (i >= 4) && ((i % 2) == 0);
            checks++;
            if (meas_valid !== ev) begin
                errors++;
                $display("FAIL div2_valid i=%0d: got %b want %b", i, meas_valid, ev);
            end
            if (ev) begin
                cnt++;
                checks++;
                if (period !== CNT_W'(2) || high_time !== CNT_W'(DUTY) ||
                    meas_count !== 16'(cnt)) begin
                    errors++;
                    $display("FAIL div2_meas i=%0d: got p=%0d h=%0d c=%0d want 2 %0d %0d",
                             i, period, high_time, meas_count, DUTY, cnt);
                end
            end
        end
    endtask

    // 5 high / 5 low: strobes at i=12,22,32.
    task automatic test_div10();
        int cnt;
        logic ev;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 10) < 5);
            ev = (i >= 12) && (((i - 12) % 10) == 0);
            checks++;
            if (meas_valid !== ev || stalled !== 1'b0) begin
                errors++;
                $display("FAIL div10_valid i=%0d: got v=%b s=%b want v=%b s=0",
                         i, meas_valid, stalled, ev);
            end
            if (ev) begin
                cnt++;
                checks++;
                if (period !== CNT_W'(10) || high_time !== CNT_W'(5 * DUTY) ||
                    meas_count !== 16'(cnt)) begin
                    errors++;
                    $display("FAIL div10_meas i=%0d: got p=%0d h=%0d c=%0d want 10 %0d %0d",
                             i, period, high_time, meas_count, 5 * DUTY, cnt);
                end
            end
        end
    endtask

    // Last load at edge 32, stall at 52, restart rise clears at 62,
    // next strobe at 72.
    task automatic test_stall();
        logic cd, ev, es;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            cd = ((i < 35) || (i >= 60)) && ((i % 10) < 5);
            cyc(cd);
            ev = (i == 12) || (i == 22) || (i == 32) || (i == 72);
            es = (i >= 52) && (i < 62);
            checks++;
            if (meas_valid !== ev || stalled !== es) begin
                errors++;
                $display("FAIL stall_seq i=%0d: got v=%b s=%b want v=%b s=%b",
                         i, meas_valid, stalled, ev, es);
            end
            if (i == 61 || i == 72) begin
                checks++;
                if (period !== CNT_W'(10) || high_time !== CNT_W'(5 * DUTY) ||
                    meas_count !== 16'((i == 61) ? 3 : 4)) begin
                    errors++;
                    $display("FAIL stall_hold i=%0d: got p=%0d h=%0d c=%0d want 10 %0d %0d",
                             i, period, high_time, meas_count, 5 * DUTY,
                             (i == 61) ? 3 : 4);
                end
            end
        end
    endtask

    // Period 20 == TIMEOUT strobes; then a period of 21 stalls for one
    // cycle (edge 62) and recovers at 63 without a strobe.
    task automatic test_timeout_edge();
        logic cd, ev, es;
        do_reset();
        for (int i = 0; i < 72; i++) begin
            cd = (i < 50) ? ((i % 20) < 10) : ((i >= 61) && (i < 71));
            cyc(cd);
            ev = (i == 22) || (i == 42);
            es = (i == 62);
            checks++;
            if (meas_valid !== ev || stalled !== es) begin
                errors++;
                $display("FAIL tmo_seq i=%0d: got v=%b s=%b want v=%b s=%b",
                         i, meas_valid, stalled, ev, es);
            end
            if (ev) begin
                checks++;
                if (period !== CNT_W'(20) || high_time !== CNT_W'(10 * DUTY)) begin
                    errors++;
                    $display("FAIL tmo_meas i=%0d: got p=%0d h=%0d want 20 %0d",
                             i, period, high_time, 10 * DUTY);
                end
            end
        end
        checks++;
        if (meas_count !== 16'd2) begin
            errors++;
            $display("FAIL tmo_count: got %0d want 2", meas_count);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic ev;
        do_reset();
        for (int i = 0; i < 17; i++)
            cyc((i % 10) < 5);
        checks++;
        if (period !== CNT_W'(10) || meas_count !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_pre: got p=%0d c=%0d want 10 1", period, meas_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({period, high_time, meas_valid, stalled, meas_count} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got p=%0d h=%0d v=%b s=%b c=%0d want all 0",
                     period, high_time, meas_valid, stalled, meas_count);
        end
        clock_div = 1'b0;
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc((i % 10) < 5);
            ev = (i >= 12) && (((i - 12) % 10) == 0);
            checks++;
            if (meas_valid !== ev) begin
                errors++;
                $display("FAIL rstmid_valid i=%0d: got %b want %b", i, meas_valid, ev);
            end
            if (ev) begin
                cnt++;
                checks++;
                if (period !== CNT_W'(10) || meas_count !== 16'(cnt)) begin
                    errors++;
                    $display("FAIL rstmid_meas i=%0d: got p=%0d c=%0d want 10 %0d",
                             i, period, meas_count, cnt);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        clock_div = 1'b0;
        test_reset();
        test_div2();
        test_div10();
        test_stall();
        test_timeout_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
